// File: rtl/dvs_ravens_pkg.sv
// Shared constants and types for the DVS camera to RAVENS event path.
// Integrators override AFULL_LVL on dvs_param_event_fifo with EVENT_QUEUE_AFULL_LVL.
package dvs_ravens_pkg;

  localparam int EVENT_BITS            = 16;
  localparam int EVENT_QUEUE_DEPTH     = 16;
  localparam int EVENT_QUEUE_AFULL_LVL = EVENT_QUEUE_DEPTH - 2;

  typedef logic [EVENT_BITS-1:0] dvs_event_t;

endpackage

// File: rtl/dvs_fifo_regfile.sv
// Event storage for dvs_param_event_fifo: one synchronous write port and one
// asynchronous read port, so the FIFO head falls through with no read latency.
module dvs_fifo_regfile #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dvs_param_event_fifo.sv
// Full-capacity, count-tracked event FIFO with valid/ready on both sides.
// Define DVS_FIFO_DROP_COUNT_EN to build the saturating dropped-event counter.
module dvs_param_event_fifo
  import dvs_ravens_pkg::*;
#(
  parameter int DATA_W    = EVENT_BITS,
  parameter int DEPTH     = EVENT_QUEUE_DEPTH,
  parameter int AFULL_LVL = DEPTH - 2,
  parameter int DROP_W    = 16,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);

  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overflow_reg;
  logic             push, pop, drop;

  // Handshake qualifiers use only registered state, so a same-cycle pop
  // never makes room for a push into a full queue.
  assign empty       = (count_reg == '0);
  assign full        = (count_reg == CNT_W'(DEPTH));
  assign almost_full = (count_reg >= CNT_W'(AFULL_LVL));
  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign count       = count_reg;
  assign overflow    = overflow_reg;

  assign push = in_valid && !full;
  assign pop  = out_ready && !empty;
  assign drop = in_valid && full;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= drop;
    end
  end

`ifdef DVS_FIFO_DROP_COUNT_EN
  logic [DROP_W-1:0] drop_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_reg <= '0;
    end else if (drop && (drop_count_reg != {DROP_W{1'b1}})) begin
      drop_count_reg <= drop_count_reg + DROP_W'(1);
    end
  end

  assign drop_count = drop_count_reg;
`else
  assign drop_count = '0;
`endif

  dvs_fifo_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_reg),
    .wdata (in_data),
    .raddr (rd_ptr_reg),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_dvs_param_event_fifo.sv
// Directed bench for dvs_param_event_fifo: a DEPTH=4/AFULL_LVL=3 instance and
// a DEPTH=5 instance for pointer wrap. Honours DVS_FIFO_DROP_COUNT_EN.
module tb_dvs_param_event_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic       v4 = 1'b0, r4 = 1'b0;
  logic [7:0] d4 = '0;
  logic       rdy4, ov4, emp4, full4, af4, ovf4;
  logic [7:0] q4;
  logic [2:0] cnt4;
  logic [15:0] drop4;

  // DEPTH=5 instance
  logic       v5 = 1'b0, r5 = 1'b0;
  logic [7:0] d5 = '0;
  logic       rdy5, ov5, emp5, full5, af5, ovf5;
  logic [7:0] q5;
  logic [2:0] cnt5;
  logic [15:0] drop5;

  dvs_param_event_fifo #(.DATA_W(8), .DEPTH(4), .AFULL_LVL(3), .DROP_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4), .in_ready(rdy4),
    .out_valid(ov4), .out_data(q4), .out_ready(r4), .count(cnt4),
    .empty(emp4), .full(full4), .almost_full(af4), .overflow(ovf4), .drop_count(drop4)
  );

  dvs_param_event_fifo #(.DATA_W(8), .DEPTH(5), .AFULL_LVL(3), .DROP_W(16)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_data(d5), .in_ready(rdy5),
    .out_valid(ov5), .out_data(q5), .out_ready(r5), .count(cnt5),
    .empty(emp5), .full(full5), .almost_full(af5), .overflow(ovf5), .drop_count(drop5)
  );

  int vectors = 0;
  int miscompares = 0;
  int exp_drops = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic note_drop();
`ifdef DVS_FIFO_DROP_COUNT_EN
    exp_drops++;
`endif
  endtask

  logic [7:0] fill_vals [4];
  logic [7:0] wrap_vals [5];

  initial begin
    fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    wrap_vals = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};

    // Reset state
    step(); step();
    rst = 1'b0;
    check("rst_count", 32'(cnt4), 0);
    check("rst_empty", 32'(emp4), 1);
    check("rst_full", 32'(full4), 0);
    check("rst_afull", 32'(af4), 0);
    check("rst_in_ready", 32'(rdy4), 1);
    check("rst_out_valid", 32'(ov4), 0);
    check("rst_overflow", 32'(ovf4), 0);
    check("rst_drop_count", 32'(drop4), 0);
    check("rst_count5", 32'(cnt5), 0);
    $display("reset: count=%0d empty=%0b in_ready=%0b", cnt4, emp4, rdy4);

    // Fill DEPTH=4 with out_ready low
    for (int i = 0; i < 4; i++) begin
      v4 = 1'b1; d4 = fill_vals[i];
      step();
      check("fill_count", 32'(cnt4), 32'(i + 1));
      check("fill_afull", 32'(af4), (i >= 2) ? 1 : 0);
      check("fill_full", 32'(full4), (i == 3) ? 1 : 0);
      check("fill_in_ready", 32'(rdy4), (i == 3) ? 0 : 1);
      $display("push %02h: count=%0d afull=%0b full=%0b", fill_vals[i], cnt4, af4, full4);
    end
    v4 = 1'b0;
    check("fill_head", 32'(q4), 32'h11);

    // Overflow: hold 0x55 against a full queue for three cycles
    for (int k = 0; k < 3; k++) begin
      v4 = 1'b1; d4 = 8'h55;
      step();
      note_drop();
      check("ovf_pulse", 32'(ovf4), 1);
      check("ovf_count", 32'(cnt4), 4);
      check("ovf_drop_count", 32'(drop4), 32'(exp_drops));
      $display("drop 55: overflow=%0b drop_count=%0d", ovf4, drop4);
    end
    v4 = 1'b0;
    step();
    check("ovf_clear", 32'(ovf4), 0);
    check("ovf_drop_hold", 32'(drop4), 32'(exp_drops));

    // Drain in order
    r4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(ov4), 1);
      check("drain_data", 32'(q4), 32'(fill_vals[i]));
      $display("pop %02h: count=%0d", q4, cnt4);
      step();
    end
    r4 = 1'b0;
    check("drain_empty", 32'(emp4), 1);
    check("drain_count", 32'(cnt4), 0);
    check("drain_out_valid", 32'(ov4), 0);

    // Simultaneous push/pop at count=2
    v4 = 1'b1; d4 = 8'hA0; step();
    d4 = 8'hA1; step();
    check("pp_pre_count", 32'(cnt4), 2);
    r4 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      d4 = 8'hA2 + 8'(k);
      check("pp_head", 32'(q4), 32'(8'hA0 + 8'(k)));
      step();
      check("pp_count", 32'(cnt4), 2);
      $display("push %02h / pop %02h: count=%0d", d4, 8'hA0 + 8'(k), cnt4);
    end
    v4 = 1'b0;
    check("pp_tail0", 32'(q4), 32'hAA);
    step();
    check("pp_tail1", 32'(q4), 32'hAB);
    step();
    r4 = 1'b0;
    check("pp_empty", 32'(emp4), 1);

    // Push and pop together while full: pop wins, push dropped
    r4 = 1'b0; v4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d4 = 8'h61 + 8'(i);
      step();
    end
    check("fp_full", 32'(full4), 1);
    d4 = 8'h77; r4 = 1'b1;
    check("fp_head", 32'(q4), 32'h61);
    step();
    note_drop();
    check("fp_overflow", 32'(ovf4), 1);
    check("fp_count", 32'(cnt4), 3);
    check("fp_drop_count", 32'(drop4), 32'(exp_drops));
    $display("push 77 / pop 61 at full: overflow=%0b count=%0d", ovf4, cnt4);
    v4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("fp_drain", 32'(q4), 32'(8'h62 + 8'(i)));
      step();
    end
    r4 = 1'b0;
    check("fp_empty", 32'(emp4), 1);

    // Reset mid-stream with count=3
    v4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d4 = 8'h81 + 8'(i);
      step();
    end
    check("mr_pre_count", 32'(cnt4), 3);
    rst = 1'b1; d4 = 8'h99;
    step();
    rst = 1'b0; v4 = 1'b0;
    check("mr_count", 32'(cnt4), 0);
    check("mr_empty", 32'(emp4), 1);
    check("mr_drop_count", 32'(drop4), 0);
    check("mr_out_valid", 32'(ov4), 0);
    check("mr_overflow", 32'(ovf4), 0);
    $display("mid-stream reset: count=%0d empty=%0b", cnt4, emp4);

    // Wrap on DEPTH=5: push 3, pop 3, push 5, pop 5
    v5 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d5 = 8'h01 + 8'(i);
      step();
    end
    v5 = 1'b0; r5 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("w5_pop_a", 32'(q5), 32'(8'h01 + 8'(i)));
      step();
    end
    r5 = 1'b0;
    check("w5_empty", 32'(emp5), 1);
    v5 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d5 = wrap_vals[i];
      step();
    end
    v5 = 1'b0;
    check("w5_full", 32'(full5), 1);
    check("w5_count", 32'(cnt5), 5);
    check("w5_in_ready", 32'(rdy5), 0);
    check("w5_afull", 32'(af5), 1);
    r5 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("w5_pop_b", 32'(q5), 32'(wrap_vals[i]));
      $display("wrap pop %02h: count=%0d", q5, cnt5);
      step();
    end
    r5 = 1'b0;
    check("w5_final_empty", 32'(emp5), 1);
    check("w5_overflow", 32'(ovf5), 0);
    check("w5_drop_count", 32'(drop5), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dvs_param_event_fifo.md
# dvs_param_event_fifo

Parametrised, full-capacity FIFO for DVS address-events. Replaces the fixed-size single-port event queue between the DVS camera front end and the RAVENS interface. Adds:
- valid/ready handshakes on both sides;
- simultaneous push and pop in one cycle;
- use of all DEPTH entries;
- an almost-full flag, so the camera side can be throttled before events are lost;
- an optional saturating dropped-event counter.

## Interface
- DATA_W, default EVENT_BITS — event word width.
- DEPTH, default EVENT_QUEUE_DEPTH — entries; any integer ≥ 2, power of two not required.
- AFULL_LVL, default DEPTH-2 — almost_full asserts when count ≥ AFULL_LVL; legal range 1..DEPTH.
- DROP_W, default 16 — dropped-event counter width.
- clk  in  1 — clock; all logic on rising edge.
- rst  in  1 — synchronous, active-high reset.
- in_valid  in  1 — producer offers in_data.
- in_data  in  DATA_W — event to push.
- in_ready  out  1 — equals !full; a push occurs on in_valid && in_ready.
- out_valid  out  1 — equals !empty; out_data holds the head event.
- out_data  out  DATA_W — head event; don't-care while out_valid = 0.
- out_ready  in  1 — consumer accepts; a pop occurs on out_valid && out_ready.
- count  out  $clog2(DEPTH+1) — current occupancy.
- empty, full, almost_full  out  1 each — status flags.
- overflow  out  1 — one-cycle pulse for each dropped event.
- drop_count  out  DROP_W — saturating count of dropped events.

## Operation
- Storage is a DEPTH-entry array with separate read pointer rd_ptr and write pointer wr_ptr, each $clog2(DEPTH) bits.
- Pointers advance by 1 and wrap from DEPTH-1 to 0 by explicit compare, not modulo on the pointer width.
- Occupancy is tracked by a count register; there is no pointer-equality flag logic.
  - empty = (count == 0); full = (count == DEPTH).
  - All DEPTH entries are usable.
- Push: writes in_data at wr_ptr and advances wr_ptr.
- Pop: advances rd_ptr.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged; both pointers advance.
- Head output: out_data = mem[rd_ptr], read combinationally (first-word fall-through).
- Drop: in_valid && full.
  - The event is discarded and the memory is untouched.
  - overflow pulses high for that cycle.
  - drop_count increments and saturates at all-ones.
  - A pop in the same cycle does not rescue the push: in_ready is !full evaluated before the edge.
- Pop while empty: impossible by handshake. out_ready with out_valid = 0 has no effect.
- There is no other state machine. The control state is {rd_ptr, wr_ptr, count, drop_count}.

## Timing
- Reset values:
  - count 0, empty 1, full 0, almost_full 0.
  - in_ready 1, out_valid 0, overflow 0, drop_count 0.
  - Pointers 0. Memory contents are not reset.
- Reset mid-operation discards all queued events on the next edge, regardless of in_valid or out_ready in that cycle.
- Push-to-pop latency: an event pushed at edge N is visible on out_data with out_valid = 1 after edge N, so it can be popped at edge N+1.
- There is no bypass of an empty FIFO within the same cycle.
- Flags and count are registered, or decoded from registered count only; none depends combinationally on in_valid or out_ready.
- Throughput: one push and one pop per cycle, sustained, at any occupancy from 1 to DEPTH-1.

## Configuration
- Macro: DVS_FIFO_DROP_COUNT_EN.
- Defined: the drop_count register and incrementer are present, as described above.
- Undefined: drop_count is tied to 0 and no register is inferred.
- overflow is always present in both builds; the port list is identical in both builds.

## Structure
- Shared package dvs_ravens_pkg holds:
  - EVENT_BITS and EVENT_QUEUE_DEPTH;
  - typedef dvs_event_t (logic [EVENT_BITS-1:0]);
  - new constant EVENT_QUEUE_AFULL_LVL, used by integrators to override AFULL_LVL.
- One sub-module, dvs_fifo_regfile:
  - parametrised DATA_W/DEPTH;
  - 1 synchronous write port (we, waddr, wdata);
  - 1 asynchronous read port (raddr, rdata).
  - This is the natural swap point for a dual-port SRAM macro later.

## Test plan
- Fill/drain, DEPTH=4, AFULL_LVL=3. Push 0x11, 0x22, 0x33, 0x44 with out_ready=0. Required:
  - count goes 1, 2, 3, 4; almost_full rises after the 3rd push; full and in_ready=0 after the 4th.
  - Popping then yields 0x11..0x44 in order, then empty=1.
- Overflow: with the DEPTH=4 FIFO full, hold in_valid for 3 cycles with 0x55. Required:
  - overflow=1 on each of those cycles; drop_count=3 (0 with macro undefined).
  - Contents unchanged; 0x55 never appears on the output.
- Simultaneous push/pop at count=2 for 10 cycles with an incrementing pattern. Required: count stays 2, and output order equals input order.
- Wrap with DEPTH=5: push 3, pop 3, then push 5. Required: full=1 and the pops return the 5 words in order, exercising pointer wrap 4→0.
- Push and pop at full: count=DEPTH, in_valid=1, out_ready=1. Required:
  - head popped, push dropped, overflow=1, count=DEPTH-1.
- Reset mid-stream: with count=3, assert rst for 1 cycle alongside in_valid=1. Required: count=0, empty=1, drop_count=0, out_valid=0 on the next cycle.
